// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_transmitter write port among NUM_REQ byte
// streams. Grants are round-robin per message, capped at MAX_BURST bytes per
// grant. Accepted bytes reach the transmitter one cycle later through a single
// register stage. The block also holds the transmitter's runtime configuration,
// which only follows cfg_* while no grant is active.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  localparam int GID_W    = $clog2(NUM_REQ),
  localparam int CNT_W    = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [1:0]           cfg_baudrate_select,
  input  logic [5:0]           cfg_threshold,
  output logic                 tx_write_enable,
  output logic [7:0]           tx_data,
  output logic [1:0]           tx_baudrate_select,
  output logic [5:0]           tx_buffer_full_threshold,
  input  logic                 tx_buffer_full,
  output logic [GID_W-1:0]     grant_id,
  output logic                 busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [GID_W-1:0]   grant_id_q;
  logic [GID_W-1:0]   last_grant_q;
  logic [CNT_W-1:0]   burst_cnt_q;
  logic               tx_we_q;
  logic [7:0]         tx_data_q;
  logic [1:0]         baud_q;
  logic [5:0]         threshold_q;

  logic [7:0]         req_bytes [NUM_REQ];
  logic               pick_found;
  logic [GID_W-1:0]   pick_id;
  logic               accept;
  logic               burst_cap_hit;
  logic               exit_grant;

  // Split the flat data bus into one byte per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // Round-robin pick: first valid requester after the last one served.
  always_comb begin
    // NOTE: every signal written here gets a default before any condition so
    // no path leaves it unassigned, which would otherwise infer a latch.
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [GID_W-1:0] cand;
      cand = GID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Next state, handshake and grant-exit decode.
  always_comb begin
    state_d       = state_q;
    req_ready     = '0;
    accept        = 1'b0;
    burst_cap_hit = 1'b0;
    exit_grant    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) state_d = GRANT;
      end
      GRANT: begin
        req_ready[grant_id_q] = !tx_buffer_full;
        accept        = req_valid[grant_id_q] && !tx_buffer_full;
        burst_cap_hit = (MAX_BURST != 0) && (int'(burst_cnt_q) + 1 == MAX_BURST);
        exit_grant    = accept && (req_last[grant_id_q] || burst_cap_hit);
        if (exit_grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grant bookkeeping, output write stage and configuration capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_id_q   <= '0;
      last_grant_q <= GID_W'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      tx_we_q      <= 1'b0;
      tx_data_q    <= '0;
      baud_q       <= '0;
      threshold_q  <= '0;
    end else begin
      tx_we_q <= accept;
      if (accept) tx_data_q <= req_bytes[grant_id_q];
      unique case (state_q)
        IDLE: begin
          baud_q      <= cfg_baudrate_select;
          threshold_q <= cfg_threshold;
          if (pick_found) begin
            grant_id_q  <= pick_id;
            burst_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (accept && (burst_cnt_q != {CNT_W{1'b1}})) burst_cnt_q <= burst_cnt_q + 1'b1;
          if (exit_grant) last_grant_q <= grant_id_q;
        end
        default: ;
      endcase
    end
  end

  assign tx_write_enable          = tx_we_q;
  assign tx_data                  = tx_data_q;
  assign tx_baudrate_select       = baud_q;
  assign tx_buffer_full_threshold = threshold_q;
  assign grant_id                 = grant_id_q;
  assign busy                     = (state_q == GRANT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Requester drivers replay queued messages; a
// message-level reference model turns each batch into the expected sequence of
// transmitter writes, and a monitor compares every write against it.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 16;
  localparam int GID_W     = $clog2(NUM_REQ);

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [GID_W-1:0] id;
    logic             busy;
    logic [7:0]       data;
  } exp_t;

  logic                 clock;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [1:0]           cfg_baudrate_select;
  logic [5:0]           cfg_threshold;
  logic                 tx_write_enable;
  logic [7:0]           tx_data;
  logic [1:0]           tx_baudrate_select;
  logic [5:0]           tx_buffer_full_threshold;
  logic                 tx_buffer_full;
  logic [GID_W-1:0]     grant_id;
  logic                 busy;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .req_valid                (req_valid),
    .req_data                 (req_data),
    .req_last                 (req_last),
    .req_ready                (req_ready),
    .cfg_baudrate_select      (cfg_baudrate_select),
    .cfg_threshold            (cfg_threshold),
    .tx_write_enable          (tx_write_enable),
    .tx_data                  (tx_data),
    .tx_baudrate_select       (tx_baudrate_select),
    .tx_buffer_full_threshold (tx_buffer_full_threshold),
    .tx_buffer_full           (tx_buffer_full),
    .grant_id                 (grant_id),
    .busy                     (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  beat_t              rq [NUM_REQ][$];
  exp_t               exp_q [$];
  int                 n_acc [NUM_REQ];
  bit                 mid [NUM_REQ];
  logic [NUM_REQ-1:0] acc_q    = '0;
  bit                 prev_acc = 1'b0;
  bit                 mon_en   = 1'b0;
  bit                 gap_en   = 1'b0;
  bit                 force_full = 1'b0;
  int                 full_pct = 0;
  int                 m_last   = NUM_REQ - 1;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_beat(input int r, input logic [7:0] d, input bit l);
    beat_t b;
    b.data = d;
    b.last = l;
    rq[r].push_back(b);
  endtask

  task automatic load_msg(input int r, input int len);
    for (int n = 0; n < len; n++) push_beat(r, 8'($urandom), n == len - 1);
  endtask

  // Reference model: whole messages served round-robin after the last
  // served requester, at most MAX_BURST bytes per turn.
  task automatic run_model();
    beat_t m [NUM_REQ][$];
    int    pick;
    int    n;
    beat_t b;
    bit    stop;
    exp_t  e;
    for (int i = 0; i < NUM_REQ; i++) m[i] = rq[i];
    forever begin
      pick = -1;
      for (int k = 1; k <= NUM_REQ; k++)
        if (pick < 0 && m[(m_last + k) % NUM_REQ].size() > 0) pick = (m_last + k) % NUM_REQ;
      if (pick < 0) break;
      n = 0;
      stop = 1'b0;
      while (!stop) begin
        b = m[pick].pop_front();
        n++;
        stop = b.last || (MAX_BURST != 0 && n == MAX_BURST);
        e.id   = GID_W'(pick);
        e.busy = !stop;
        e.data = b.data;
        exp_q.push_back(e);
      end
      m_last = pick;
    end
  endtask

  // Requester and backpressure drivers, updated just after each rising edge.
  initial begin
    beat_t b;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_buffer_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_acc[i] = 0;
      mid[i] = 1'b0;
    end
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_q[i] && rq[i].size() > 0) begin
          b = rq[i].pop_front();
          n_acc[i]++;
          mid[i] = !b.last;
        end
        if (rq[i].size() == 0) mid[i] = 1'b0;
        if (rq[i].size() > 0) begin
          req_valid[i]        = !(gap_en && mid[i] && $urandom_range(0, 3) == 0);
          req_data[8*i +: 8]  = rq[i][0].data;
          req_last[i]         = rq[i][0].last;
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = 8'h00;
          req_last[i]         = 1'b0;
        end
      end
      tx_buffer_full = force_full || ($urandom_range(0, 99) < full_pct);
    end
  end

  // Monitor: handshake rules, write latency and the write scoreboard.
  initial begin
    logic [NUM_REQ-1:0] acc_now;
    exp_t e;
    forever begin
      @(negedge clock);
      acc_now = req_valid & req_ready;
      if (mon_en) begin
        if (tx_write_enable || prev_acc)
          check("write_latency", 32'(tx_write_enable), 32'(prev_acc));
        if (req_ready != '0)
          check("ready_rule", 32'(busy && !tx_buffer_full && $onehot(req_ready)), 1);
        if (tx_write_enable) begin
          if (exp_q.size() == 0) begin
            check("spurious_write", 32'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            check("tx_write", 32'({grant_id, busy, tx_data}), 32'(e));
          end
        end
      end
      acc_q    = acc_now;
      prev_acc = |acc_now;
    end
  end

  task automatic drain(input int budget, output int busy_n, output int span);
    int c;
    int first_b;
    int last_b;
    c = 0;
    busy_n = 0;
    first_b = -1;
    last_b = -1;
    while (c < budget && !(queues_empty() && exp_q.size() == 0)) begin
      @(negedge clock);
      #1;
      if (busy) begin
        busy_n++;
        if (first_b < 0) first_b = c;
        last_b = c;
      end
      c++;
    end
    span = (first_b < 0) ? 0 : last_b - first_b + 1;
    check("drain_complete", 32'(queues_empty() && exp_q.size() == 0), 1);
    repeat (2) @(posedge clock);
  endtask

  initial begin
    int bn;
    int sp;
    int c;
    reset = 1'b0;
    cfg_baudrate_select = 2'd0;
    cfg_threshold = 6'd0;

    // Reset values.
    #12;
    check("rst_write_enable", 32'(tx_write_enable), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_baud", 32'(tx_baudrate_select), 0);
    check("rst_threshold", 32'(tx_buffer_full_threshold), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(req_ready), 0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    mon_en = 1'b1;

    // Four requesters with single-byte messages, req0 twice.
    @(posedge clock);
    #2;
    push_beat(0, 8'h10, 1'b1);
    push_beat(0, 8'h11, 1'b1);
    push_beat(1, 8'h21, 1'b1);
    push_beat(2, 8'h32, 1'b1);
    push_beat(3, 8'h43, 1'b1);
    run_model();
    drain(200, bn, sp);
    check("rr_busy_cycles", 32'(bn), 5);
    check("rr_busy_span", 32'(sp), 9);

    // Three-byte message from req0.
    @(posedge clock);
    #2;
    push_beat(0, 8'h55, 1'b0);
    push_beat(0, 8'hA3, 1'b0);
    push_beat(0, 8'h0F, 1'b1);
    run_model();
    drain(200, bn, sp);
    check("msg3_busy_cycles", 32'(bn), 3);

    // Backpressure held for 10 cycles mid-message.
    @(posedge clock);
    #2;
    for (int i = 0; i < NUM_REQ; i++) n_acc[i] = 0;
    load_msg(0, 12);
    run_model();
    c = 0;
    while (n_acc[0] < 4 && c < 100) begin
      @(posedge clock);
      #2;
      c++;
    end
    check("bp_progress", 32'(n_acc[0] >= 4), 1);
    force_full = 1'b1;
    @(posedge clock);
    #2;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("bp_ready_low", 32'(req_ready), 0);
      if (k > 0) check("bp_no_write", 32'(tx_write_enable), 0);
    end
    force_full = 1'b0;
    drain(300, bn, sp);

    // Configuration frozen while granted.
    @(posedge clock);
    #2;
    load_msg(0, 6);
    run_model();
    c = 0;
    @(negedge clock);
    while (!busy && c < 50) begin
      @(negedge clock);
      c++;
    end
    check("cfg_grant_seen", 32'(busy), 1);
    #2;
    cfg_baudrate_select = 2'd2;
    cfg_threshold = 6'd33;
    c = 0;
    @(negedge clock);
    while (busy && c < 200) begin
      check("cfg_baud_frozen", 32'(tx_baudrate_select), 0);
      @(negedge clock);
      c++;
    end
    check("cfg_baud_first_idle", 32'(tx_baudrate_select), 0);
    @(negedge clock);
    check("cfg_baud_updated", 32'(tx_baudrate_select), 2);
    check("cfg_threshold_updated", 32'(tx_buffer_full_threshold), 33);
    drain(300, bn, sp);

    // Reset while req2 holds the grant with a write in flight.
    @(posedge clock);
    #2;
    load_msg(2, 8);
    run_model();
    c = 0;
    @(negedge clock);
    while (!(tx_write_enable && busy) && c < 50) begin
      @(negedge clock);
      c++;
    end
    check("mid_write_pending", 32'(tx_write_enable), 1);
    check("mid_grant_before", 32'(grant_id), 2);
    #2;
    reset = 1'b0;
    mon_en = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    exp_q.delete();
    m_last = NUM_REQ - 1;
    #1;
    check("mid_rst_write_enable", 32'(tx_write_enable), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_grant_id", 32'(grant_id), 0);
    check("mid_rst_baud", 32'(tx_baudrate_select), 0);
    cfg_baudrate_select = 2'd0;
    cfg_threshold = 6'd0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    mon_en = 1'b1;

    // Burst cap splits req0's 20-byte message around req1's byte.
    @(posedge clock);
    #2;
    load_msg(0, 20);
    load_msg(1, 1);
    run_model();
    drain(300, bn, sp);

    // Random batches: short messages with valid gaps, then long messages.
    full_pct = 30;
    for (int pass = 0; pass < 2; pass++) begin
      gap_en = (pass == 0);
      for (int bt = 0; bt < 6; bt++) begin
        @(posedge clock);
        #2;
        for (int r = 0; r < NUM_REQ; r++) begin
          int nm;
          nm = (r == bt % NUM_REQ) ? 1 + $urandom_range(0, 2) : $urandom_range(0, 3);
          for (int m = 0; m < nm; m++)
            load_msg(r, (pass == 0) ? $urandom_range(1, 16) : $urandom_range(1, 40));
        end
        run_model();
        drain(6000, bn, sp);
      end
    end
    full_pct = 0;
    repeat (4) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
